med: RTL and testbench

- Registered median-of-three selector for unsigned samples.
- Each accepted cycle it compares data0, data1 and data2 and outputs the median, the minimum, the maximum and the three pairwise compare flags.
- Used as a small filter/selection primitive, e.g. a 3-tap median filter stage in a datapath.

---
 rtl/med.sv | 124 ++++++++++++
 tb/tb_med.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/med.sv
// Registered median-of-three selector: median, min, max and pairwise compare flags
// for unsigned samples, with a 1- or 2-stage pipeline.
module med #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_med,
  output logic [WIDTH-1:0] data_min,
  output logic [WIDTH-1:0] data_max,
  output logic             com_01,
  output logic             com_02,
  output logic             com_12
);

  // Selection-stage operands: samples, flags and valid feeding the output registers.
  logic [WIDTH-1:0] sel_d0, sel_d1, sel_d2;
  logic             sel_f01, sel_f02, sel_f12;
  logic             sel_v;

  logic [WIDTH-1:0] med_d, min_d, max_d;

  generate
    if (PIPE == 1) begin : g_pipe1
      assign sel_d0  = data0;
      assign sel_d1  = data1;
      assign sel_d2  = data2;
      assign sel_f01 = data0 > data1;
      assign sel_f02 = data0 > data2;
      assign sel_f12 = data1 > data2;
      assign sel_v   = in_valid;
    end else if (PIPE == 2) begin : g_pipe2
      logic [WIDTH-1:0] d0_q, d1_q, d2_q;
      logic             f01_q, f02_q, f12_q;
      logic             v_q;

      // Stage 1 captures flags alongside the samples they were computed from.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d0_q  <= '0;
          d1_q  <= '0;
          d2_q  <= '0;
          f01_q <= 1'b0;
          f02_q <= 1'b0;
          f12_q <= 1'b0;
          v_q   <= 1'b0;
        end else begin
          v_q <= in_valid;
          if (in_valid) begin
            d0_q  <= data0;
            d1_q  <= data1;
            d2_q  <= data2;
            f01_q <= data0 > data1;
            f02_q <= data0 > data2;
            f12_q <= data1 > data2;
          end
        end
      end

      assign sel_d0  = d0_q;
      assign sel_d1  = d1_q;
      assign sel_d2  = d2_q;
      assign sel_f01 = f01_q;
      assign sel_f02 = f02_q;
      assign sel_f12 = f12_q;
      assign sel_v   = v_q;
    end else begin : g_bad_pipe
      $error("med: PIPE must be 1 or 2");
    end
  endgenerate

  // Flag-driven selection; exactly one branch matches for any input, ties included.
  always_comb begin
    med_d = sel_d2;
    if (sel_f01 ^ sel_f02) begin
      med_d = sel_d0;
    end else if (sel_f01 == sel_f12) begin
      med_d = sel_d1;
    end

    max_d = sel_d2;
    if (sel_f01 && sel_f02) begin
      max_d = sel_d0;
    end else if (sel_f12) begin
      max_d = sel_d1;
    end

    min_d = sel_d2;
    if (!sel_f01 && !sel_f02) begin
      min_d = sel_d0;
    end else if (!sel_f12) begin
      min_d = sel_d1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_med  <= '0;
      data_min  <= '0;
      data_max  <= '0;
      com_01    <= 1'b0;
      com_02    <= 1'b0;
      com_12    <= 1'b0;
    end else begin
      out_valid <= sel_v;
      if (sel_v) begin
        data_med <= med_d;
        data_min <= min_d;
        data_max <= max_d;
        com_01   <= sel_f01;
        com_02   <= sel_f02;
        com_12   <= sel_f12;
      end
    end
  end

endmodule

// File: tb/tb_med.sv
// Bench for med: PIPE=1 and PIPE=2 instances share stimulus; a sort-based model feeds
// per-instance scoreboard queues, the PIPE=2 queue is primed one entry deep.
module tb_med;
  localparam int unsigned W = 3;

  typedef struct packed {
    logic         v;
    logic [W-1:0] med;
    logic [W-1:0] mn;
    logic [W-1:0] mx;
    logic         f01;
    logic         f02;
    logic         f12;
  } item_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0, data2 = '0;

  logic         ov1, ov2;
  logic [W-1:0] med1, mn1, mx1, med2, mn2, mx2;
  logic         a1, b1, c1, a2, b2, c2;
  item_t        o1, o2;

  item_t q1[$];
  item_t q2[$];
  item_t last;
  int    total = 0;
  int    bad = 0;

  med #(.WIDTH(W), .PIPE(1)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .data0(data0), .data1(data1), .data2(data2),
    .out_valid(ov1), .data_med(med1), .data_min(mn1), .data_max(mx1),
    .com_01(a1), .com_02(b1), .com_12(c1)
  );

  med #(.WIDTH(W), .PIPE(2)) u_p2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .data0(data0), .data1(data1), .data2(data2),
    .out_valid(ov2), .data_med(med2), .data_min(mn2), .data_max(mx2),
    .com_01(a2), .com_02(b2), .com_12(c2)
  );

  assign o1 = {ov1, med1, mn1, mx1, a1, b1, c1};
  assign o2 = {ov2, med2, mn2, mx2, a2, b2, c2};

  always #5 clk = ~clk;

  function automatic item_t ref_model(logic v, logic [W-1:0] a, logic [W-1:0] b,
                                      logic [W-1:0] c, item_t prev);
    logic [W-1:0] s[3];
    logic [W-1:0] t;
    item_t        r;
    r   = prev;
    r.v = v;
    if (v) begin
      s[0] = a;
      s[1] = b;
      s[2] = c;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2 - i; j++) begin
          if (s[j] > s[j+1]) begin
            t      = s[j];
            s[j]   = s[j+1];
            s[j+1] = t;
          end
        end
      end
      r.mn  = s[0];
      r.med = s[1];
      r.mx  = s[2];
      r.f01 = a > b;
      r.f02 = a > c;
      r.f12 = b > c;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flush_model();
    q1.delete();
    q2.delete();
    last = '0;
    q2.push_back('0);
  endtask

  task automatic step(logic v, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
    item_t e;
    in_valid = v;
    data0    = a;
    data1    = b;
    data2    = c;
    e        = ref_model(v, a, b, c, last);
    last     = e;
    q1.push_back(e);
    q2.push_back(e);
    @(posedge clk);
    #1;
    chk("pipe1", {3'b0, o1}, {3'b0, q1.pop_front()});
    chk("pipe2", {3'b0, o2}, {3'b0, q2.pop_front()});
    if (v && ov1) begin
      chk("min_le_med", {15'b0, mn1 <= med1}, 16'd1);
      chk("med_le_max", {15'b0, med1 <= mx1}, 16'd1);
      chk("sum", 16'(mn1) + 16'(med1) + 16'(mx1), 16'(a) + 16'(b) + 16'(c));
    end
  endtask

  initial begin
    last = '0;
    // Reset held with live valid inputs must keep everything at zero.
    rst      = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      data0 = W'($urandom);
      data1 = W'($urandom);
      data2 = W'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_hold_p1", {3'b0, o1}, 16'd0);
    chk("rst_hold_p2", {3'b0, o2}, 16'd0);
    #2 rst = 1'b0;
    flush_model();

    step(1'b1, 3'd1, 3'd3, 3'd2);
    chk("d132_p1", {3'b0, o1}, {3'b0, 1'b1, 3'd2, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1});
    step(1'b0, 3'd0, 3'd0, 3'd0);
    chk("d132_p2", {3'b0, o2}, {3'b0, 1'b1, 3'd2, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1});

    step(1'b1, 3'd5, 3'd5, 3'd2);
    chk("d552", {3'b0, o1}, {3'b0, 1'b1, 3'd5, 3'd2, 3'd5, 1'b0, 1'b1, 1'b1});
    step(1'b1, 3'd0, 3'd0, 3'd0);
    chk("d000", {3'b0, o1}, {3'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    step(1'b1, 3'd7, 3'd7, 3'd7);
    chk("d777", {3'b0, o1}, {3'b0, 1'b1, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0});

    // Single valid pulse, then changing data with valid low must leave the result held.
    step(1'b1, 3'd6, 3'd0, 3'd4);
    chk("d604", {3'b0, o1}, {3'b0, 1'b1, 3'd4, 3'd0, 3'd6, 1'b1, 1'b1, 1'b0});
    step(1'b0, 3'd1, 3'd2, 3'd3);
    chk("gate_p1", {12'b0, ov1, med1}, {12'b0, 1'b0, 3'd4});
    chk("gate_p2", {12'b0, ov2, med2}, {12'b0, 1'b1, 3'd4});
    step(1'b0, 3'd7, 3'd0, 3'd5);
    chk("hold_p2", {12'b0, ov2, med2}, {12'b0, 1'b0, 3'd4});
    step(1'b0, 3'd2, 3'd2, 3'd2);

    for (int i = 0; i < 512; i++) begin
      step(1'b1, W'(i >> 6), W'(i >> 3), W'(i));
    end
    step(1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 3'd0, 3'd0);

    // Asynchronous reset between clock edges with both stages loaded.
    step(1'b1, 3'd3, 3'd1, 3'd2);
    in_valid = 1'b1;
    data0    = 3'd6;
    data1    = 3'd5;
    data2    = 3'd4;
    rst      = 1'b1;
    #1;
    chk("async_rst_p1", {3'b0, o1}, 16'd0);
    chk("async_rst_p2", {3'b0, o2}, 16'd0);
    #2 rst = 1'b0;
    flush_model();
    step(1'b0, 3'd1, 3'd1, 3'd1);
    chk("flush_p2", {3'b0, o2}, 16'd0);
    step(1'b0, 3'd2, 3'd2, 3'd2);
    step(1'b1, 3'd1, 3'd3, 3'd2);
    step(1'b0, 3'd0, 3'd0, 3'd0);
    chk("restart_p2", {3'b0, o2}, {3'b0, 1'b1, 3'd2, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
